// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, debouncer, edge tick and sticky pending flag
module edge_detect_multi #(
  parameter int N_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_level,
  input  logic [1:0]      i_mode,
  input  logic [N_CH-1:0] i_clr,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_tick,
  output logic [N_CH-1:0] o_pending
);
  localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  genvar c;
  for (c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sr;
    logic [CW-1:0] cnt;
    logic deb, tick, pend, sync, upd, tick_next;
    assign sync = sr[SYNC_STAGES-1];
    // the update event: sync has differed from deb for DB_CYCLES consecutive cycles
    assign upd = (sync != deb) && (cnt == CNT_MAX);
    assign tick_next = upd & (sync ? i_mode[0] : i_mode[1]);
    assign o_level[c] = deb;
    assign o_tick[c] = tick;
    assign o_pending[c] = pend;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sr <= '0;
        cnt <= '0;
        deb <= 1'b0;
        tick <= 1'b0;
        pend <= 1'b0;
      end else begin
        sr <= {sr[SYNC_STAGES-2:0], i_level[c]};
        cnt <= (sync == deb || upd) ? '0 : cnt + 1'b1;
        deb <= upd ? sync : deb;
        tick <= tick_next;
        pend <= (pend & ~i_clr[c]) | tick_next;
      end
    end
  end
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: table vectors, corner sequences and random traffic against a history-based model
module tb_edge_detect_multi;
  localparam int N = 4, S = 2, D = 4, H = S + D;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] level = '0, clr = '0;
  logic [1:0] mode = 2'b01;
  logic [N-1:0] o_level, o_tick, o_pending;
  logic lv1 = 1'b0, clr1 = 1'b0, lvl1, tick1, pend1;
  logic [7:0] lv8 = '0, clr8 = '0, lvl8, tick8, pend8;
  int vectors = 0, miscompares = 0, cyc = 0;

  always #5 clk = ~clk;

  edge_detect_multi dut (.i_clk(clk), .i_rst(rst), .i_level(level), .i_mode(mode), .i_clr(clr),
    .o_level(o_level), .o_tick(o_tick), .o_pending(o_pending));
  edge_detect_multi #(.N_CH(1), .SYNC_STAGES(3), .DB_CYCLES(1)) dut1 (.i_clk(clk), .i_rst(rst),
    .i_level(lv1), .i_mode(mode), .i_clr(clr1), .o_level(lvl1), .o_tick(tick1), .o_pending(pend1));
  edge_detect_multi #(.N_CH(8), .DB_CYCLES(16)) dut8 (.i_clk(clk), .i_rst(rst),
    .i_level(lv8), .i_mode(mode), .i_clr(clr8), .o_level(lvl8), .o_tick(tick8), .o_pending(pend8));

  // model: hist[j] is the raw level sampled j edges ago; the debouncer sees hist[S..S+D-1]
  logic [N-1:0] hist [H];
  logic [N-1:0] m_level, m_tick, m_pend;
  logic all_diff;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < H; j++) hist[j] = '0;
      m_level = '0;
      m_tick = '0;
      m_pend = '0;
    end else begin
      for (int j = H - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = level;
      m_tick = '0;
      for (int c = 0; c < N; c++) begin
        all_diff = 1'b1;
        for (int j = S; j < S + D; j++) if (hist[j][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_tick[c] = m_level[c] ? mode[1] : mode[0];
          m_level[c] = ~m_level[c];
        end
      end
      m_pend = (m_pend & ~clr) | m_tick;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    chk("model_level", 8'(o_level), 8'(m_level));
    chk("model_tick", 8'(o_tick), 8'(m_tick));
    chk("model_pending", 8'(o_pending), 8'(m_pend));
  endtask

  typedef struct {
    logic [3:0] lv;
    logic [1:0] md;
    logic [3:0] cl;
    logic [3:0] e_lv, e_seen, e_pend;
  } vec_t;
  vec_t tbl[8];
  logic [3:0] seen;
  int rise_n, fall_n, tog, last_t;
  logic prev2;

  initial begin
    tbl[0] = '{4'b0001, 2'b01, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    tbl[1] = '{4'b0000, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[2] = '{4'b0000, 2'b01, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[3] = '{4'b1010, 2'b11, 4'b0000, 4'b1010, 4'b1010, 4'b1010};
    tbl[4] = '{4'b0010, 2'b10, 4'b0000, 4'b0010, 4'b1000, 4'b1010};
    tbl[5] = '{4'b1111, 2'b00, 4'b1010, 4'b1111, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0000, 2'b10, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
    tbl[7] = '{4'b0000, 2'b11, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    repeat (3) @(negedge clk);
    chk("reset_level", 8'(o_level), 8'h00);
    chk("reset_tick", 8'(o_tick), 8'h00);
    chk("reset_pending", 8'(o_pending), 8'h00);
    rst = 1'b0;

    foreach (tbl[i]) begin
      level = tbl[i].lv;
      mode = tbl[i].md;
      clr = tbl[i].cl;
      seen = '0;
      for (int k = 0; k < 10; k++) begin
        step();
        clr = '0;
        seen |= o_tick;
      end
      chk($sformatf("tbl%0d_level", i), 8'(o_level), 8'(tbl[i].e_lv));
      chk($sformatf("tbl%0d_ticks", i), 8'(seen), 8'(tbl[i].e_seen));
      chk($sformatf("tbl%0d_pending", i), 8'(o_pending), 8'(tbl[i].e_pend));
    end

    // exact step latency on ch0, mode 01
    mode = 2'b01;
    level = 4'b0001;
    for (int x = 0; x <= 6; x++) begin
      step();
      chk("lat_level0", 8'(o_level[0]), 8'(x >= 5));
      chk("lat_tick0", 8'(o_tick[0]), 8'(x == 5));
      chk("lat_others", 8'({o_level[3:1], o_tick[3:1]}), 8'h00);
    end
    chk("lat_pending0", 8'(o_pending[0]), 8'h01);

    // glitch rejection then acceptance on ch1
    level[1] = 1'b1;
    seen = '0;
    repeat (3) step();
    level[1] = 1'b0;
    repeat (12) begin
      step();
      seen |= o_level | o_tick;
    end
    chk("glitch_rejected", 8'(seen[1]), 8'h00);
    chk("glitch_pending", 8'(o_pending[1]), 8'h00);
    level[1] = 1'b1;
    seen = '0;
    repeat (4) step();
    level[1] = 1'b0;
    repeat (12) begin
      step();
      seen |= o_tick;
    end
    chk("pulse4_tick", 8'(seen[1]), 8'h01);
    chk("pulse4_pending", 8'(o_pending[1]), 8'h01);

    // mode sweep on ch2 square wave
    for (int m = 0; m < 4; m++) begin
      mode = (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : (m == 2) ? 2'b11 : 2'b00;
      rise_n = 0; fall_n = 0; tog = 0; last_t = -1;
      prev2 = o_level[2];
      for (int k = 0; k < 40; k++) begin
        if (k % 10 == 0) level[2] = ~level[2];
        step();
        if (o_level[2] != prev2) tog++;
        prev2 = o_level[2];
        if (o_tick[2]) begin
          if (o_level[2]) rise_n++; else fall_n++;
          if (mode == 2'b11 && last_t >= 0) chk("both_spacing", 8'(cyc - last_t), 8'd10);
          last_t = cyc;
        end
      end
      chk($sformatf("sweep%0d_rise", m), 8'(rise_n), (m == 0 || m == 2) ? 8'd2 : 8'd0);
      chk($sformatf("sweep%0d_fall", m), 8'(fall_n), (m == 1 || m == 2) ? 8'd2 : 8'd0);
      chk($sformatf("sweep%0d_toggles", m), 8'(tog), 8'd4);
    end

    // pending clear, then clear coinciding with a tick on ch3
    mode = 2'b01;
    level[3] = 1'b1;
    repeat (10) step();
    chk("pend3_set", 8'(o_pending[3]), 8'h01);
    clr = 4'b1000;
    step();
    clr = '0;
    chk("pend3_cleared", 8'(o_pending[3]), 8'h00);
    mode = 2'b10;
    level[3] = 1'b0;
    repeat (5) step();
    clr = 4'b1000;
    step();
    clr = '0;
    chk("coincide_tick", 8'(o_tick[3]), 8'h01);
    chk("coincide_pending", 8'(o_pending[3]), 8'h01);
    step();
    chk("coincide_hold", 8'(o_pending[3]), 8'h01);

    // parameter variants
    mode = 2'b01;
    lv1 = 1'b1;
    for (int x = 0; x <= 4; x++) begin
      step();
      chk("v1_level", 8'(lvl1), 8'(x >= 3));
      chk("v1_tick", 8'(tick1), 8'(x == 3));
    end
    lv8 = 8'h01;
    for (int x = 0; x <= 18; x++) begin
      step();
      chk("v8_level", lvl8, 8'(x >= 17));
      chk("v8_tick", tick8, 8'(x == 17));
    end

    // asynchronous reset while ch0 count is 2
    level = '0;
    repeat (10) step();
    level[0] = 1'b1;
    repeat (4) step();
    chk("prereset_pending", 8'(o_pending != 0), 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("async_level", 8'(o_level), 8'h00);
    chk("async_pending", 8'(o_pending), 8'h00);
    chk("async_tick", 8'(o_tick), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int x = 0; x <= 6; x++) begin
      step();
      chk("postrst_level0", 8'(o_level[0]), 8'(x >= 5));
      chk("postrst_tick0", 8'(o_tick[0]), 8'(x == 5));
    end

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 5) == 0) level[c] = ~level[c];
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
